// File: rtl/alu_arbiter_if.sv
// alu_arbiter_if: request, ALU and response bundle for the shared-ALU arbiter.
// slave = arbiter side, master = requesters / ALU / response consumer side.
interface alu_arbiter_if #(
    parameter int ARB_ID_W = 1
);
    logic                req0_valid;
    logic                req0_ready;
    logic [7:0]          req0_a;
    logic [7:0]          req0_b;
    logic [2:0]          req0_op;
    logic                req1_valid;
    logic                req1_ready;
    logic [7:0]          req1_a;
    logic [7:0]          req1_b;
    logic [2:0]          req1_op;
    logic [7:0]          alu_a;
    logic [7:0]          alu_b;
    logic [2:0]          alu_op;
    logic [7:0]          alu_result;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [7:0]          rsp_data;
    logic [ARB_ID_W-1:0] rsp_id;

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_op,
        output req0_ready,
        input  req1_valid, req1_a, req1_b, req1_op,
        output req1_ready,
        output alu_a, alu_b, alu_op,
        input  alu_result,
        output rsp_valid, rsp_data, rsp_id,
        input  rsp_ready
    );

    modport master (
        output req0_valid, req0_a, req0_b, req0_op,
        input  req0_ready,
        output req1_valid, req1_a, req1_b, req1_op,
        input  req1_ready,
        input  alu_a, alu_b, alu_op,
        output alu_result,
        input  rsp_valid, rsp_data, rsp_id,
        output rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// alu_arbiter: shares one 8-bit ALU between two requesters (IDLE/EXEC/RESP).
// Define ALU_ARB_RR_EN for round-robin tie-break; otherwise requester 0 wins ties.
module alu_arbiter #(
    parameter int ARB_ID_W = 1
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t r_state;
    logic   r_id;
`ifdef ALU_ARB_RR_EN
    logic   r_last;
`endif

    logic w_any;
    logic w_gnt;
    logic w_idle;
    logic w_hs;

    // Grant pick in IDLE; readys are forced low outside IDLE and during reset
    always_comb begin
        w_any = bus.req0_valid | bus.req1_valid;
`ifdef ALU_ARB_RR_EN
        if (bus.req0_valid && bus.req1_valid) begin
            w_gnt = ~r_last;
        end else begin
            w_gnt = ~bus.req0_valid;
        end
`else
        w_gnt = ~bus.req0_valid;
`endif
        w_idle = (r_state == S_IDLE) && !rst;
        w_hs   = w_idle && w_any;
        bus.req0_ready = w_idle && bus.req0_valid && !w_gnt;
        bus.req1_ready = w_idle && bus.req1_valid && w_gnt;
    end

    // Sequencer: latch the granted op, execute one cycle, hold the response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= S_IDLE;
            r_id          <= 1'b0;
            bus.alu_a     <= 8'd0;
            bus.alu_b     <= 8'd0;
            bus.alu_op    <= 3'd0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= 8'd0;
            bus.rsp_id    <= '0;
`ifdef ALU_ARB_RR_EN
            r_last        <= 1'b1;
`endif
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_hs) begin
                        bus.alu_a  <= w_gnt ? bus.req1_a  : bus.req0_a;
                        bus.alu_b  <= w_gnt ? bus.req1_b  : bus.req0_b;
                        bus.alu_op <= w_gnt ? bus.req1_op : bus.req0_op;
                        r_id       <= w_gnt;
`ifdef ALU_ARB_RR_EN
                        r_last     <= w_gnt;
`endif
                        r_state    <= S_EXEC;
                    end
                end
                S_EXEC: begin
                    bus.rsp_data  <= bus.alu_result;
                    bus.rsp_id    <= ARB_ID_W'(r_id);
                    bus.rsp_valid <= 1'b1;
                    r_state       <= S_RESP;
                end
                S_RESP: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Sequencer that shares the single 8-bit ALU (add / subtract / pass-B) between two requesters. Each requester presents an operation with a valid/ready handshake; the arbiter grants one, drives the ALU operand and op lines for one execute cycle, captures the result and returns it on a single tagged response channel with backpressure. It sits between the CPU control logic and the shared ALU and is the only block that drives the ALU inputs.

## Interface
- `ARB_ID_W`, default 1: width of `rsp_id`; fixed at 1 for two requesters.
- `clk` input 1: system clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `req0_valid` input 1: requester 0 has an operation pending.
- `req0_ready` output 1: requester 0 operation accepted this cycle.
- `req0_a`, `req0_b` input 8 each: requester 0 operands.
- `req0_op` input 3: requester 0 ALU op (0 add, 1 sub, 2 pass B, 3–7 yield 0).
- `req1_valid`, `req1_ready`, `req1_a`, `req1_b`, `req1_op`: same as requester 0, for requester 1.
- `alu_a`, `alu_b` output 8 each: registered operands to the ALU.
- `alu_op` output 3: registered op to the ALU.
- `alu_result` input 8: combinational ALU result.
- `rsp_valid` output 1: response available.
- `rsp_ready` input 1: consumer accepts the response.
- `rsp_data` output 8: captured ALU result.
- `rsp_id` output 1: requester that issued the operation.

## Operation
- FSM states: IDLE, EXEC, RESP. Reset state is IDLE.
- **IDLE.** The grant is computed combinationally from the two valids and `last_grant`.
  - With one valid, that requester is granted.
  - With both valid, the requester not equal to `last_grant` is granted.
  - Only the granted requester sees `ready` = 1; both readys are 0 in every other state.
  - On handshake (valid & ready), latch a/b/op into `alu_a`/`alu_b`/`alu_op`, latch the id, update `last_grant`, and go to EXEC.
  - With no valid, stay in IDLE.
- **EXEC.** `alu_*` are stable for the whole cycle. At the closing edge, capture `alu_result` into `rsp_data`, set `rsp_id` and `rsp_valid`, and go to RESP.
- **RESP.** `rsp_valid` = 1; `rsp_data` and `rsp_id` are held stable.
  - On `rsp_valid & rsp_ready`, clear `rsp_valid` and go to IDLE.
  - Otherwise stay in RESP indefinitely.
- Arithmetic is 8-bit modulo 256 with no carry or flags: 255+1 = 0, 0−1 = 255. The op is passed to the ALU unmodified, and ops 3–7 return 0.
- Requesters must hold operands stable only in the handshake cycle; the arbiter samples them only on handshake. A requester may drop valid before it is granted; it is then simply not served.
- `alu_a`, `alu_b` and `alu_op` hold the last issued operation outside EXEC.

## Timing
- Reset values:
  - state = IDLE;
  - `last_grant` = 1, so requester 0 wins the first tie;
  - `alu_a` = `alu_b` = 0, `alu_op` = 0;
  - `rsp_valid` = 0, `rsp_data` = 0, `rsp_id` = 0;
  - `req0_ready` = `req1_ready` = 0 while `rst` is asserted.
- Latency:
  - Handshake in cycle N, EXEC in cycle N+1, `rsp_valid` high in cycle N+2.
  - With `rsp_ready` held at 1, the next handshake is possible in cycle N+3.
  - Peak throughput is therefore one operation per 3 cycles.
- Requests arriving in EXEC or RESP wait; their readys stay 0.
- Simultaneous events:
  - A valid arriving in the same cycle `rsp_ready` completes RESP is not accepted until the following IDLE cycle.
  - `rsp_ready` asserted outside RESP is ignored.
- Reset mid-operation (EXEC or RESP) returns to IDLE immediately and forces `rsp_valid` to 0. The in-flight operation is discarded and no response is produced.

## Configuration
- `ALU_ARB_RR_EN` defined: round-robin tie-break using `last_grant`, as described above.
- `ALU_ARB_RR_EN` undefined: fixed priority, requester 0 always wins ties. `last_grant` is not implemented, and all other behaviour is identical.

## Test plan
- **Add:** req0 only with a=1, b=2, op=0 → handshake at cycle 0; `rsp_valid`=1 at cycle 2 with `rsp_data`=3, `rsp_id`=0.
- **Tie after reset:** both valid, req0 a=15, b=8, op=1 and req1 a=255, b=1, op=0.
  - First response: data 7, id 0.
  - Second response: data 0 (wrap), id 1.
  - Without `ALU_ARB_RR_EN`, requester 0 is still first.
- **Fairness:** both valid continuously for 6 operations → ids alternate 0,1,0,1,0,1 with round-robin; all six ids are 0 without the macro.
- **Backpressure:** `rsp_ready`=0 for 5 cycles during RESP with pass-B, b=128 → `rsp_valid`, `rsp_data`=128 and `rsp_id` stay stable; both readys stay 0; IDLE is reached one cycle after `rsp_ready` rises.
- **Reset in EXEC:** assert `rst` during EXEC of 100−100 → `rsp_valid` stays 0 and no response appears; after release, req1 with 0−255 returns 1 with id 1.
- **Unused op:** op=5 with a=42, b=101 → `rsp_data`=0 after the normal 2-cycle latency.
